// File: rtl/dcache.sv
// Direct-mapped write-back/write-allocate data cache, 8 blocks x 4 bytes, single-cycle hits.
// A miss holds BUSYWAIT high through optional WRITEBACK, FETCH and FILL; memory stalls the transfer via MEM_BUSYWAIT.
module dcache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITE_DATA,
  output logic [7:0]  READ_DATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;

  state_t      state, state_nxt;
  logic [7:0]  valid, dirty;
  logic [2:0]  tag_arr  [8];
  logic [31:0] data_arr [8];

  logic [2:0]  addr_tag, addr_idx;
  logic [1:0]  addr_off;
  logic [4:0]  bit_off;
  logic        req, hit, wr_hit_en, fill_en;
  logic [7:0]  cur_byte;

  assign addr_tag = ADDRESS[7:5];
  assign addr_idx = ADDRESS[4:2];
  assign addr_off = ADDRESS[1:0];
  assign bit_off  = {addr_off, 3'b000};
  assign req      = READ | WRITE;
  assign hit      = valid[addr_idx] && (tag_arr[addr_idx] == addr_tag);
  assign cur_byte = data_arr[addr_idx][bit_off +: 8];

  // Everything is gated by RESET so outputs fall to 0 the moment reset asserts.
  always_comb begin
    state_nxt     = state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'd0;
    MEM_WRITEDATA = 32'd0;
    READ_DATA     = 8'd0;
    wr_hit_en     = 1'b0;
    fill_en       = 1'b0;
    if (RESET) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (WRITE) wr_hit_en = 1'b1;
              else       READ_DATA = cur_byte;
            end else begin
              BUSYWAIT  = 1'b1;
              state_nxt = (valid[addr_idx] && dirty[addr_idx]) ? WRITEBACK : FETCH;
            end
          end
        end
        WRITEBACK: begin
          BUSYWAIT      = 1'b1;
          MEM_WRITE     = 1'b1;
          MEM_ADDRESS   = {tag_arr[addr_idx], addr_idx};
          MEM_WRITEDATA = data_arr[addr_idx];
          if (!MEM_BUSYWAIT) state_nxt = FETCH;
        end
        FETCH: begin
          BUSYWAIT    = 1'b1;
          MEM_READ    = 1'b1;
          MEM_ADDRESS = ADDRESS[7:2];
          if (!MEM_BUSYWAIT) begin
            fill_en   = 1'b1;
            state_nxt = FILL;
          end
        end
        FILL: begin
          BUSYWAIT  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      valid <= 8'd0;
      dirty <= 8'd0;
    end else begin
      state <= state_nxt;
      if (fill_en) begin
        valid[addr_idx] <= 1'b1;
        dirty[addr_idx] <= 1'b0;
      end else if (wr_hit_en) begin
        dirty[addr_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_arr[addr_idx]  <= addr_tag;
      data_arr[addr_idx] <= MEM_READDATA;
    end else if (wr_hit_en) begin
      data_arr[addr_idx][bit_off +: 8] <= WRITE_DATA;
    end
  end

endmodule
